// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: op codes, flag bit positions, FSM states.
package exec_pkg;

  localparam logic [2:0] EXEC_OP_ADD  = 3'd0;
  localparam logic [2:0] EXEC_OP_SUB  = 3'd1;
  localparam logic [2:0] EXEC_OP_AND  = 3'd2;
  localparam logic [2:0] EXEC_OP_OR   = 3'd3;
  localparam logic [2:0] EXEC_OP_XOR  = 3'd4;
  localparam logic [2:0] EXEC_OP_MUL  = 3'd5;
  localparam logic [2:0] EXEC_OP_DIVU = 3'd6;
  localparam logic [2:0] EXEC_OP_PASS = 3'd7;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == EXEC_OP_MUL) || (op == EXEC_OP_DIVU);
  endfunction

endpackage

// File: rtl/exec_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per i_step.
// Result is {hi, lo}: product for multiply, {remainder, quotient} for divide.
module exec_iter_muldiv #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic                      i_step,
  input  logic                      i_div,
  input  logic [DATA_WIDTH-1:0]     i_a,
  input  logic [DATA_WIDTH-1:0]     i_b,
  output logic                      o_last_c,
  output logic [2*DATA_WIDTH-1:0]   o_result
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_b;
  logic             r_div;
  logic [CNT_W-1:0] r_count;

  logic [W:0]       w_shift;
  logic [W:0]       w_trial;
  logic [W:0]       w_madd;
  logic [W-1:0]     w_hi_nxt;
  logic [W-1:0]     w_lo_nxt;

  // Divide shifts the dividend MSB into the remainder; multiply adds under lo[0].
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_madd  = {1'b0, r_hi} + {1'b0, r_b & {W{r_lo[0]}}};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_div) begin
      if (!w_trial[W]) begin
        w_hi_nxt = w_trial[W-1:0];
        w_lo_nxt = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[W-1:0];
        w_lo_nxt = {r_lo[W-2:0], 1'b0};
      end
    end else begin
      {w_hi_nxt, w_lo_nxt} = {w_madd, r_lo[W-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_count <= '0;
    end else if (i_start) begin
      r_hi    <= '0;
      r_lo    <= i_a;
      r_b     <= i_b;
      r_div   <= i_div;
      r_count <= '0;
    end else if (i_step) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last_c = (r_count == CNT_W'(W - 1));
  assign o_result = {r_hi, r_lo};

endmodule

// File: rtl/execute_multicycle.sv
// Execute stage: forwarding mux, single-cycle ALU, valid/ready FSM and flags register.
// Define EXEC_MULDIV_EN to build the iterative multiply/divide unit for ops 5/6.
module execute_multicycle
  import exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FWD_SOURCES = 3,
  parameter int unsigned SEL_WIDTH   = $clog2(FWD_SOURCES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2:0]                        op,
  input  logic                              invert_top,
  input  logic [SEL_WIDTH-1:0]              sel_top,
  input  logic [SEL_WIDTH-1:0]              sel_bot,
  input  logic [FWD_SOURCES*DATA_WIDTH-1:0] fwd_top,
  input  logic [FWD_SOURCES*DATA_WIDTH-1:0] fwd_bot,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2*DATA_WIDTH-1:0]           result,
  output logic [FLAG_W-1:0]                 flags_out,
  output logic [FLAG_W-1:0]                 flags_cur,
  output logic                              busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W1 = W + 1;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_out_valid;
  logic [2*W-1:0]      r_result;
  logic [FLAG_W-1:0]   r_flags_out;
  logic [FLAG_W-1:0]   r_flags_cur;
  logic                r_busy;

  logic [W-1:0]        w_top;
  logic [W-1:0]        w_bot;
  logic [W:0]          w_add;
  logic [W:0]          w_sub;
  logic [2*W-1:0]      w_alu_res;
  logic [FLAG_W-1:0]   w_alu_flg;
  logic [2*W-1:0]      w_md_res;
  logic [FLAG_W-1:0]   w_md_flg;
  logic                w_accept;
  logic                w_multi;
  logic                w_last;

  // Out-of-range selects yield zero.
  always_comb begin
    w_top = '0;
    w_bot = '0;
    for (int k = 0; k < FWD_SOURCES; k++) begin
      if (sel_top == SEL_WIDTH'(k)) w_top = fwd_top[k*W +: W];
      if (sel_bot == SEL_WIDTH'(k)) w_bot = fwd_bot[k*W +: W];
    end
    w_top = w_top ^ {W{invert_top}};
  end

  assign w_add = {1'b0, w_top} + {1'b0, w_bot};
  assign w_sub = {1'b0, w_top} + {1'b0, ~w_bot} + W1'(1);

  // Ops 5/6 fall to the default arm only when the iterative unit is absent.
  always_comb begin
    w_alu_res = '0;
    w_alu_flg = '0;
    case (op)
      EXEC_OP_ADD: begin
        w_alu_res[W-1:0]  = w_add[W-1:0];
        w_alu_flg[FLAG_C] = w_add[W];
        w_alu_flg[FLAG_V] = (w_top[W-1] == w_bot[W-1]) && (w_add[W-1] != w_top[W-1]);
      end
      EXEC_OP_SUB: begin
        w_alu_res[W-1:0]  = w_sub[W-1:0];
        w_alu_flg[FLAG_C] = w_sub[W];
        w_alu_flg[FLAG_V] = (w_top[W-1] != w_bot[W-1]) && (w_sub[W-1] != w_top[W-1]);
      end
      EXEC_OP_AND:  w_alu_res[W-1:0] = w_top & w_bot;
      EXEC_OP_OR:   w_alu_res[W-1:0] = w_top | w_bot;
      EXEC_OP_XOR:  w_alu_res[W-1:0] = w_top ^ w_bot;
      EXEC_OP_PASS: w_alu_res = {w_top, w_bot};
      default:      w_alu_flg[FLAG_V] = 1'b1;
    endcase
    w_alu_flg[FLAG_Z] = (w_alu_res[W-1:0] == '0);
    w_alu_flg[FLAG_N] = w_alu_res[W-1];
  end

  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
  logic r_is_div;
  logic r_div_zero;

  assign w_multi = is_muldiv(op);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_is_div   <= (op == EXEC_OP_DIVU);
      r_div_zero <= (w_bot == '0);
    end
  end

  exec_iter_muldiv #(
    .DATA_WIDTH (W)
  ) u_iter (
    .clock    (clock),
    .reset    (reset),
    .i_start  (w_accept && w_multi),
    .i_step   (r_state == ST_CALC),
    .i_div    (op == EXEC_OP_DIVU),
    .i_a      (w_top),
    .i_b      (w_bot),
    .o_last_c (w_last),
    .o_result (w_md_res)
  );

  // MUL zero tests the full product; divide-by-zero reports through V.
  always_comb begin
    w_md_flg         = '0;
    w_md_flg[FLAG_N] = w_md_res[W-1];
    if (r_is_div) begin
      w_md_flg[FLAG_Z] = (w_md_res[W-1:0] == '0);
      w_md_flg[FLAG_V] = r_div_zero;
    end else begin
      w_md_flg[FLAG_Z] = (w_md_res == '0);
      w_md_flg[FLAG_V] = |w_md_res[2*W-1:W];
    end
  end
`else
  assign w_multi  = 1'b0;
  assign w_last   = 1'b0;
  assign w_md_res = '0;
  assign w_md_flg = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_multi) w_state_nxt = ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // PASS leaves both flag registers untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags_out <= '0;
      r_flags_cur <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept && !w_multi) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        if (op != EXEC_OP_PASS) begin
          r_flags_out <= w_alu_flg;
          r_flags_cur <= w_alu_flg;
        end
      end else if (r_state == ST_DONE) begin
        r_out_valid <= 1'b1;
        r_result    <= w_md_res;
        r_flags_out <= w_md_flg;
        r_flags_cur <= w_md_flg;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags_out = r_flags_out;
  assign flags_cur = r_flags_cur;
  assign busy      = r_busy;

endmodule
